// File: rtl/pattern_tx.sv
// pattern_tx: serial transmitter for a fixed PAT_W-bit pattern, MSB first,
// repeated repeat_n times with a programmable idle gap between copies.
module pattern_tx #(
    parameter int                PAT_W   = 6,
    parameter logic [PAT_W-1:0]  PATTERN = 6'b101011,
    parameter int                CNT_W   = 8,
    parameter int                GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    // r_idx is the index of the pattern bit currently on the line.
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_reps;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_out;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    state_t           w_state;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W-1:0] w_reps;
    logic [GAP_W-1:0] w_gap_len;
    logic [GAP_W-1:0] w_gap_cnt;
    logic             w_emit;
    logic             w_out;
    logic             w_valid;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_reps    = r_reps;
        w_gap_len = r_gap_len;
        w_gap_cnt = r_gap_cnt;
        w_emit    = 1'b0;
        w_out     = 1'b0;
        w_valid   = 1'b0;
        w_last    = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state   = S_SEND;
                    w_reps    = (repeat_n == '0) ? REP_ONE : repeat_n;
                    w_gap_len = gap;
                    w_gap_cnt = '0;
                    w_idx     = IDX_TOP;
                    w_emit    = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_idx != '0) begin
                    w_idx  = r_idx - 1'b1;
                    w_emit = 1'b1;
                end else if (r_reps > REP_ONE) begin
                    w_reps = r_reps - 1'b1;
                    if (r_gap_len == '0) begin
                        w_idx  = IDX_TOP;
                        w_emit = 1'b1;
                    end else begin
                        w_state   = S_GAP;
                        w_gap_cnt = r_gap_len;
                        w_busy    = 1'b1;
                    end
                end else begin
                    w_state = S_DONE;
                    w_reps  = r_reps - 1'b1;
                    w_busy  = 1'b1;
                    w_done  = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_gap_cnt <= GAP_ONE) begin
                    w_state   = S_SEND;
                    w_gap_cnt = '0;
                    w_idx     = IDX_TOP;
                    w_emit    = 1'b1;
                end else begin
                    w_gap_cnt = r_gap_cnt - 1'b1;
                    w_busy    = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_emit) begin
            w_out   = PATTERN[w_idx];
            w_valid = 1'b1;
            w_last  = (w_idx == '0);
            w_busy  = 1'b1;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_reps    <= '0;
            r_gap_len <= '0;
            r_gap_cnt <= '0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_reps    <= w_reps;
            r_gap_len <= w_gap_len;
            r_gap_cnt <= w_gap_cnt;
            r_out     <= w_out;
            r_valid   <= w_valid;
            r_last    <= w_last;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign out        = r_out;
    assign out_valid  = r_valid;
    assign frame_last = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
